// File: rtl/svfloat_pkg.sv
// Shared binary32 constants, rounding-mode and converter state encodings for the svfloat units.
package svfloat_pkg;

  localparam int F32_BIAS  = 127;
  localparam int F32_EXP_W = 8;
  localparam int F32_MAN_W = 23;

  // Biased exponent of a 32-bit magnitude whose MSB sits at bit 31.
  localparam logic [F32_EXP_W-1:0] F32_EXP_TOP = F32_EXP_W'(F32_BIAS + 31);

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } rmode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } itof_state_t;

endpackage

// File: rtl/svfloat_round.sv
// Combinational binary32 rounder: takes a normalised 24-bit significand plus guard/sticky
// and packs the rounded result. Unknown rounding-mode encodings fall back to RNE.
module svfloat_round
  import svfloat_pkg::*;
(
  input  logic                 sign_i,
  input  logic [F32_EXP_W-1:0] exp_i,
  input  logic [F32_MAN_W:0]   sig_i,
  input  logic                 g_i,
  input  logic                 s_i,
  input  logic [2:0]           rmode_i,
  output logic [31:0]          result_o,
  output logic                 inexact_o
);

  logic                 inexact;
  logic                 round_up;
  logic [F32_MAN_W+1:0] sig_sum;
  logic [F32_EXP_W-1:0] exp_out;
  logic [F32_MAN_W-1:0] man_out;

  always_comb begin
    inexact = g_i | s_i;
    case (rmode_i)
      RTZ:     round_up = 1'b0;
      RDN:     round_up = sign_i & inexact;
      RUP:     round_up = ~sign_i & inexact;
      RMM:     round_up = g_i;
      default: round_up = g_i & (s_i | sig_i[0]);
    endcase

    sig_sum = {1'b0, sig_i} + (F32_MAN_W+2)'(round_up);
    // All-ones significand rolled over: renormalise by bumping the exponent.
    if (sig_sum[F32_MAN_W+1]) begin
      man_out = '0;
      exp_out = exp_i + 1'b1;
    end else begin
      man_out = sig_sum[F32_MAN_W-1:0];
      exp_out = exp_i;
    end

    result_o  = {sign_i, exp_out, man_out};
    inexact_o = inexact;
  end

endmodule

// File: rtl/svfloat_itof_seq.sv
// Iterative 32-bit integer to binary32 converter with a multi-cycle normalising shift loop.
// Optional macro SVFLOAT_ITOF_RMODE_EN adds a selectable rounding mode (in_rmode).
module svfloat_itof_seq
  import svfloat_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_signed,
`ifdef SVFLOAT_ITOF_RMODE_EN
  input  logic [2:0]  in_rmode,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_inexact
);

  itof_state_t          state_q, state_d;
  logic [31:0]          mag_q, mag_d;
  logic [F32_EXP_W-1:0] exp_q, exp_d;
  logic                 sign_q, sign_d;
  logic [31:0]          data_q, data_d;
  logic                 inexact_q, inexact_d;
  logic [2:0]           rmode_q, rmode_d;

  logic [31:0]          rnd_result;
  logic                 rnd_inexact;

`ifdef SVFLOAT_ITOF_RMODE_EN
  logic [2:0] rmode_in;
  assign rmode_in = in_rmode;
`else
  logic [2:0] rmode_in;
  assign rmode_in = RNE;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mag_q     <= '0;
      exp_q     <= '0;
      sign_q    <= 1'b0;
      data_q    <= '0;
      inexact_q <= 1'b0;
      rmode_q   <= RNE;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      exp_q     <= exp_d;
      sign_q    <= sign_d;
      data_q    <= data_d;
      inexact_q <= inexact_d;
      rmode_q   <= rmode_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    exp_d     = exp_q;
    sign_d    = sign_q;
    data_d    = data_q;
    inexact_d = inexact_q;
    rmode_d   = rmode_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_signed & in_data[31];
          // Negating 0x80000000 wraps back to itself, which is the correct magnitude.
          mag_d   = sign_d ? (32'd0 - in_data) : in_data;
          exp_d   = F32_EXP_TOP;
          rmode_d = rmode_in;
          if (mag_d == 32'd0) begin
            data_d    = '0;
            inexact_d = 1'b0;
            state_d   = DONE;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (mag_q[31]) begin
          state_d = ROUND;
        end else if (mag_q[31 -: SHIFT_STEP] == '0) begin
          mag_d = mag_q << SHIFT_STEP;
          exp_d = exp_q - F32_EXP_W'(SHIFT_STEP);
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 1'b1;
        end
      end
      ROUND: begin
        data_d    = rnd_result;
        inexact_d = rnd_inexact;
        state_d   = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  svfloat_round u_round (
    .sign_i    (sign_q),
    .exp_i     (exp_q),
    .sig_i     (mag_q[31:8]),
    .g_i       (mag_q[7]),
    .s_i       (|mag_q[6:0]),
    .rmode_i   (rmode_q),
    .result_o  (rnd_result),
    .inexact_o (rnd_inexact)
  );

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_data    = data_q;
  assign out_inexact = inexact_q;

endmodule

// File: tb/tb_svfloat_itof_seq.sv
// Self-checking bench for svfloat_itof_seq: directed cases, back-pressure, reset abort and
// randomized conversions against an arithmetic reference model.
module tb_svfloat_itof_seq;

  localparam int SHIFT_STEP = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_signed;
`ifdef SVFLOAT_ITOF_RMODE_EN
  logic [2:0]  in_rmode;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_inexact;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  svfloat_itof_seq #(.SHIFT_STEP(SHIFT_STEP)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_signed   (in_signed),
`ifdef SVFLOAT_ITOF_RMODE_EN
    .in_rmode    (in_rmode),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_inexact (out_inexact)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: locate the leading one, keep 24 bits, round using the discarded remainder.
  task automatic ref_itof(input logic [31:0] d, input logic sg, input logic [2:0] rm,
                          output logic [31:0] res, output logic inx, output int lat);
    logic        s;
    logic [31:0] m;
    longint      sig, rem, half;
    int          msb, sh, e, lz;
    logic        up;
    s = sg & d[31];
    m = s ? (32'd0 - d) : d;
    if (m == 32'd0) begin
      res = 32'd0; inx = 1'b0; lat = 0;
      return;
    end
    msb = 31;
    while (m[msb] == 1'b0) msb--;
    lz  = 31 - msb;
    lat = lz / SHIFT_STEP + lz % SHIFT_STEP + 2;
    up  = 1'b0;
    if (msb <= 23) begin
      sig = longint'(m) << (23 - msb);
      inx = 1'b0;
    end else begin
      sh   = msb - 23;
      sig  = longint'(m) >> sh;
      rem  = longint'(m) & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      inx  = (rem != 0);
      case (rm)
        3'b001:  up = 1'b0;
        3'b010:  up = s & inx;
        3'b011:  up = ~s & inx;
        3'b100:  up = (rem >= half);
        default: up = (rem > half) || ((rem == half) && (sig % 2 == 1));
      endcase
    end
    sig = sig + longint'(up);
    e   = msb + 127;
    if (sig == (64'd1 << 24)) begin
      sig = 64'd1 << 23;
      e++;
    end
    res = {s, e[7:0], sig[22:0]};
  endtask

  task automatic run_conv(input string tag, input logic [31:0] d, input logic sg, input logic [2:0] rm,
                          input logic [31:0] exp_data, input logic exp_inx, input int exp_lat);
    int lat;
    @(negedge clk);
    check_eq({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_data   = d;
    in_signed = sg;
`ifdef SVFLOAT_ITOF_RMODE_EN
    in_rmode  = rm;
`endif
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, " data"}, out_data, exp_data);
    check_eq({tag, " inexact"}, 32'(out_inexact), 32'(exp_inx));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check_eq({tag, " release"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run_model(input string tag, input logic [31:0] d, input logic sg, input logic [2:0] rm);
    logic [31:0] r;
    logic        x;
    int          l;
    ref_itof(d, sg, rm, r, x, l);
    run_conv(tag, d, sg, rm, r, x, l);
  endtask

  task automatic run_directed(input string tag, input logic [31:0] d, input logic sg, input logic [2:0] rm,
                              input logic [31:0] exp_data, input logic exp_inx);
    logic [31:0] r;
    logic        x;
    int          l;
    ref_itof(d, sg, rm, r, x, l);
    run_conv(tag, d, sg, rm, exp_data, exp_inx, l);
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] d;
    logic        sg;
    logic [2:0]  rm;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_signed = 1'b0; out_ready = 1'b0;
`ifdef SVFLOAT_ITOF_RMODE_EN
    in_rmode = 3'b000;
`endif
    #12;
    check_eq("rst in_ready", 32'(in_ready), 32'd1);
    check_eq("rst out_valid", 32'(out_valid), 32'd0);
    check_eq("rst out_data", out_data, 32'd0);
    check_eq("rst out_inexact", 32'(out_inexact), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_directed("one",        32'h0000_0001, 1'b0, 3'b000, 32'h3F80_0000, 1'b0);
    run_directed("zero_u",     32'h0000_0000, 1'b0, 3'b000, 32'h0000_0000, 1'b0);
    run_directed("zero_s",     32'h0000_0000, 1'b1, 3'b000, 32'h0000_0000, 1'b0);
    run_directed("minus_one",  32'hFFFF_FFFF, 1'b1, 3'b000, 32'hBF80_0000, 1'b0);
    run_directed("int_min",    32'h8000_0000, 1'b1, 3'b000, 32'hCF00_0000, 1'b0);
    run_directed("umax",       32'hFFFF_FFFF, 1'b0, 3'b000, 32'h4F80_0000, 1'b1);
    run_directed("tie_even",   32'h0100_0001, 1'b0, 3'b000, 32'h4B80_0000, 1'b1);
    run_directed("tie_up",     32'h0100_0003, 1'b0, 3'b000, 32'h4B80_0002, 1'b1);
`ifdef SVFLOAT_ITOF_RMODE_EN
    run_directed("rup",        32'h0100_0001, 1'b0, 3'b011, 32'h4B80_0001, 1'b1);
    run_directed("rdn",        32'hFEFF_FFFF, 1'b1, 3'b010, 32'hCB80_0001, 1'b1);
`endif

    // Back-pressure: result must hold and a new operand must not be taken.
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h0000_1234; in_signed = 1'b0;
    @(posedge clk);
    #1 in_data = 32'h0000_0007;
    for (int i = 0; i < 100 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("bp valid", 32'(out_valid), 32'd1);
    held = out_data;
    check_eq("bp data", held, 32'h4591_A000);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check_eq("bp hold", out_data, held);
      check_eq("bp in_ready", 32'(in_ready), 32'd0);
    end
    check_eq("bp still valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check_eq("bp released", 32'(in_ready), 32'd1);
    run_model("after_bp", 32'h0000_0007, 1'b0, 3'b000);

    // Reset in the middle of normalisation.
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h0000_0001; in_signed = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("abort out_valid", 32'(out_valid), 32'd0);
    check_eq("abort in_ready", 32'(in_ready), 32'd1);
    check_eq("abort out_data", out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_directed("five", 32'h0000_0005, 1'b0, 3'b000, 32'h40A0_0000, 1'b0);

    for (int i = 0; i < 150; i++) begin
      d  = $urandom >> $urandom_range(0, 31);
      sg = 1'($urandom_range(0, 1));
      if (sg && $urandom_range(0, 1) == 1) d = 32'd0 - d;
`ifdef SVFLOAT_ITOF_RMODE_EN
      rm = 3'($urandom_range(0, 7));
`else
      rm = 3'b000;
`endif
      run_model("rand", d, sg, rm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/svfloat_itof_seq.md
Name: svfloat_itof_seq

Overview:
- Iterative converter from a 32-bit integer (signed or unsigned) to an IEEE-754 binary32 float.
- Produces the float operands consumed by svfloat_mul/div/add/sub, so integer datapaths can feed the float units.
- Valid/ready on both sides; one conversion in flight.
- Normalisation is a multi-cycle shift loop, sized for small area.

Parameters:
- SHIFT_STEP, 1, bits shifted per NORM cycle when the top SHIFT_STEP bits are all zero. Legal values: 1, 2, 4, 8.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  operand valid
- in_ready  output  1  converter can accept an operand
- in_data  input  32  integer operand
- in_signed  input  1  1 = in_data is two's complement, 0 = unsigned
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_data  output  32  binary32 result
- out_inexact  output  1  result was rounded

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; in_ready=1.
  - out_valid=0, out_data=0, out_inexact=0.
  - Internal mag, exp and sign registers cleared.
- IDLE:
  - in_ready=1.
  - Accept when in_valid&in_ready.
  - sign = in_signed & in_data[31].
  - mag = sign ? -in_data : in_data (32-bit). 0x80000000 signed gives magnitude 0x80000000.
  - exp = 158 (bias 127 + 31).
  - If mag==0: out_data=0x00000000, out_inexact=0, go to DONE.
  - Otherwise go to NORM.
- NORM, evaluated each cycle:
  - If mag[31]=1: go to ROUND.
  - Else if mag[31 -: SHIFT_STEP]==0: mag<<=SHIFT_STEP, exp-=SHIFT_STEP.
  - Else: mag<<=1, exp-=1.
  - exp never drops below 127, so no subnormal or zero exponent is produced.
- ROUND (default round-to-nearest-even):
  - man = mag[30:8], g = mag[7], s = |mag[6:0].
  - Round up when g & (s | mag[8]).
  - If man overflows (all ones +1): man=0, exp+=1.
  - out_data = {sign, exp[7:0], man}; out_inexact = g|s.
  - Go to DONE.
- DONE:
  - out_valid=1; out_data and out_inexact held stable while out_ready=0.
  - On out_ready: out_valid=0, go to IDLE.
- in_ready=0 in NORM, ROUND and DONE. No accept on the handoff cycle; the next accept is earliest the cycle after leaving DONE.
- Latency, with N = number of NORM shift cycles and the accepting edge as edge 0:
  - out_valid rises after edge N+2.
  - Zero input: out_valid rises after edge 0.
  - SHIFT_STEP=1: N = leading-zero count of mag; worst case 33 edges, for input 1.
- Reset mid-operation: conversion discarded, outputs return to reset values immediately.
- Overflow to infinity is impossible: max exponent is 159.

Optional Feature:
- SVFLOAT_ITOF_RMODE_EN defined:
  - Adds port in_rmode (input, 3 bits), captured on accept, RISC-V encoding.
  - 000 RNE, 001 RTZ (never round up), 010 RDN (up iff sign & (g|s)), 011 RUP (up iff ~sign & (g|s)), 100 RMM (up iff g).
  - Other encodings behave as RNE.
- Undefined: no in_rmode port; RNE fixed.
- out_inexact is identical in both builds.

Decomposition:
- svfloat_pkg holds:
  - F32_BIAS=127, F32_EXP_W=8, F32_MAN_W=23.
  - rmode_t enum (RNE, RTZ, RDN, RUP, RMM).
  - itof_state_t enum (IDLE, NORM, ROUND, DONE).
- One combinational sub-module, svfloat_round:
  - Inputs: sign, exp, 24-bit significand, g, s, rmode.
  - Outputs: packed result, inexact.
  - Reusable by later float-to-float and float-to-int converters.

Test Plan:
- Unsigned 0x00000001, SHIFT_STEP=1 -> 0x3F800000, inexact=0, out_valid after edge 33.
- Value 0 (signed and unsigned) -> 0x00000000, inexact=0, out_valid after edge 0; signed 0xFFFFFFFF -> 0xBF800000.
- Signed 0x80000000 -> 0xCF000000, inexact=0; unsigned 0xFFFFFFFF -> 0x4F800000 (significand overflow), inexact=1.
- Unsigned 0x01000001 -> 0x4B800000, inexact=1 (tie to even); 0x01000003 -> 0x4B800002, inexact=1 (tie rounds up). With SVFLOAT_ITOF_RMODE_EN: 0x01000001 with RUP -> 0x4B800001; signed -16777217 with RDN -> 0xCB800001.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE -> out_data stable, in_ready=0, second in_valid not accepted until out_ready pulse.
- Assert rst during NORM of input 1 -> out_valid=0 and in_ready=1 immediately; next conversion of 5 -> 0x40A00000.
